music_player_ctrl: RTL and testbench
====================================

MUSIC_PLAYER_CTRL -- requirements
Module: music_player_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 6: note-index width per song (64 words per song).
REQ-002 SHALL have parameter DUR_W, default 12: note-duration field width, in ticks.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port song_sel  in  2  current song index from the song-selection FSM.
REQ-006 SHALL have port start  in  1  one-cycle pulse: restart playback of song_sel.
REQ-007 SHALL have port pause_tgl  in  1  one-cycle pulse: toggle play/pause.
REQ-008 SHALL have port tick  in  1  one-cycle timebase strobe (1 ms nominal).
REQ-009 SHALL have port mem_data  in  16  song ROM word, 1-cycle registered read: [15:12] note code, [11:0] duration.
REQ-010 SHALL have port mem_addr  out  2+IDX_W  song ROM address {song_sel_latched, index}.
REQ-011 SHALL have port note_out  out  4  current note code to the tone generator.
REQ-012 SHALL have port note_valid  out  1  high while a sounding (non-rest) note plays.
REQ-013 SHALL have port song_end  out  1  one-cycle pulse at end of song; drives force_prox of the song-selection FSM.
REQ-014 SHALL have port playing  out  1  high in FETCH, LOAD and PLAY.

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, PLAY, PAUSE, DONE.
REQ-016 start SHALL, from any state, latch song_sel, clear index and enter FETCH next cycle; start has priority over every other event.
REQ-017 FETCH SHALL present mem_addr and go to LOAD unconditionally; LOAD SHALL sample mem_data.
REQ-018 In LOAD, note code 4'hF SHALL be the end marker and go to DONE.
REQ-019 In LOAD, duration 0 with a non-end note code SHALL skip the word: increment index, then FETCH.
REQ-020 In LOAD, any other word SHALL register note_out and the duration counter, set note_valid = (note != 0; code 0 is a rest), and go to PLAY.
REQ-021 Latency: start sampled in cycle N -> mem_addr valid in N+1 -> note_valid/note_out updated in N+3.
REQ-022 In PLAY, each tick SHALL decrement the counter; on a tick with counter==1, index SHALL increment and the state SHALL go to FETCH.
REQ-023 note_out/note_valid SHALL hold their values through FETCH/LOAD between notes and change only in LOAD or DONE.
REQ-024 Index wrap: completing the note at index 2^IDX_W-1 SHALL go to DONE, not wrap to 0.
REQ-025 DONE SHALL pulse song_end for exactly one cycle, clear note_valid and note_out, then go to IDLE.
REQ-026 pause_tgl SHALL switch PLAY<->PAUSE and SHALL be ignored in all other states.
REQ-027 In PAUSE, ticks SHALL be ignored, the counter and index SHALL be held, and note_valid SHALL be forced low; resuming restores note_valid = (note != 0).
REQ-028 pause_tgl and the final tick in the same cycle: the tick SHALL win (advance to FETCH), and pause_tgl is dropped.
REQ-029 start with pause_tgl or tick in the same cycle SHALL behave as start alone.
REQ-030 IDLE SHALL wait for start with outputs at their reset values.

Reset
REQ-031 reset low at a clock edge SHALL force IDLE, index=0, counter=0, latched song=0, mem_addr=0, note_out=0, note_valid=0, song_end=0, playing=0, overriding start.
REQ-032 Reset mid-note SHALL abort with no song_end pulse.

Structure
REQ-033 A shared music_defs include SHALL hold the state encodings, END_NOTE=4'hF, REST_NOTE=4'h0, field positions of the ROM word, IDX_W and DUR_W.
REQ-034 The tick-driven down-counter SHALL be a sub-module note_timer (load, enable, tick, zero-next flag).

Verification
REQ-035 Song 2 = {note 3 dur 2, note F}, start pulse -> mem_addr 0x80 at N+1; note_out=3, note_valid=1 at N+3; after 2 ticks mem_addr 0x81; song_end pulses once; note_valid=0.
REQ-036 Word {note 0, dur 5} -> note_out=0, note_valid=0, playing=1 for 5 ticks.
REQ-037 Word {note 7, dur 0} at index 0 -> skipped; index 1 is loaded with no note_valid pulse for note 7.
REQ-038 pause_tgl in PLAY, 10 ticks, pause_tgl -> remaining duration unchanged and note_valid low only while paused; pause_tgl coincident with the final tick -> FETCH, not PAUSE.
REQ-039 Song of 64 non-end words -> song_end after index 63; mem_addr never wraps to {song,0}.
REQ-040 reset low during PLAY with start high -> all outputs 0 and state IDLE next cycle, no song_end; start during PLAY -> restart at index 0 of the new song_sel.

Source files
------------

// File: rtl/music_player_ctrl_pkg.sv
// Shared music definitions: FSM state encodings, special note codes,
// song ROM word field positions and default widths.
package music_player_ctrl_pkg;

    localparam int DEFAULT_IDX_W = 6;
    localparam int DEFAULT_DUR_W = 12;

    localparam logic [3:0] END_NOTE  = 4'hF;
    localparam logic [3:0] REST_NOTE = 4'h0;

    // ROM word layout: [15:12] note code, [11:0] duration in ticks
    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 12;
    localparam int DUR_MSB  = 11;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/music_player_ctrl_if.sv
// Player bus: control strobes from the song-selection side, song ROM port
// and tone-generator outputs. The player is the slave side.
interface music_player_ctrl_if #(
    parameter int IDX_W = 6
);
    logic [1:0]       song_sel;
    logic             start;
    logic             pause_tgl;
    logic             tick;
    logic [15:0]      mem_data;
    logic [IDX_W+1:0] mem_addr;
    logic [3:0]       note_out;
    logic             note_valid;
    logic             song_end;
    logic             playing;

    modport master (
        output song_sel, start, pause_tgl, tick, mem_data,
        input  mem_addr, note_out, note_valid, song_end, playing
    );

    modport slave (
        input  song_sel, start, pause_tgl, tick, mem_data,
        output mem_addr, note_out, note_valid, song_end, playing
    );
endinterface

// File: rtl/note_timer.sv
// Tick-driven note duration down-counter; zero_next flags the tick that
// finishes the current note.
module note_timer
    import music_player_ctrl_pkg::*;
#(
    parameter int DUR_W = DEFAULT_DUR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             enable,
    input  logic             tick,
    output logic             zero_next
);

    logic [DUR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && tick && (cnt != '0)) begin
            cnt <= cnt - DUR_W'(1);
        end
    end

    assign zero_next = enable && tick && (cnt == DUR_W'(1));

endmodule

// File: rtl/music_player_ctrl.sv
// Song playback controller: walks one song of the ROM word by word, times
// each note on the tick strobe and reports the end of the song.
module music_player_ctrl
    import music_player_ctrl_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W,
    parameter int DUR_W = DEFAULT_DUR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    music_player_ctrl_if.slave        bus
);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [1:0]       song_lat, song_n;
    logic [3:0]       note_r, note_n;
    logic             nv_r, nv_n;

    logic             tmr_load;
    logic             tmr_done;
    logic [3:0]       word_note;
    logic [DUR_W-1:0] word_dur;
    logic             last_idx;

    assign word_note = bus.mem_data[NOTE_MSB:NOTE_LSB];
    assign word_dur  = DUR_W'(bus.mem_data[DUR_MSB:DUR_LSB]);
    assign last_idx  = (idx == {IDX_W{1'b1}});

    note_timer #(.DUR_W(DUR_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_val  (word_dur),
        .enable    ((state == PLAY) && !bus.start),
        .tick      (bus.tick),
        .zero_next (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            song_lat <= '0;
            note_r   <= REST_NOTE;
            nv_r     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            song_lat <= song_n;
            note_r   <= note_n;
            nv_r     <= nv_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        song_n   = song_lat;
        note_n   = note_r;
        nv_n     = nv_r;
        tmr_load = 1'b0;

        if (bus.start) begin
            state_n = FETCH;
            song_n  = bus.song_sel;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: ;
                FETCH: state_n = LOAD;
                LOAD: begin
                    // A zero-length word on the last index ends the song rather than wrapping
                    if ((word_note == END_NOTE) || ((word_dur == '0) && last_idx)) begin
                        state_n = DONE;
                        note_n  = REST_NOTE;
                        nv_n    = 1'b0;
                    end else if (word_dur == '0) begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = FETCH;
                    end else begin
                        note_n   = word_note;
                        nv_n     = (word_note != REST_NOTE);
                        tmr_load = 1'b1;
                        state_n  = PLAY;
                    end
                end
                PLAY: begin
                    // The finishing tick outranks a coincident pause toggle
                    if (tmr_done) begin
                        if (last_idx) begin
                            state_n = DONE;
                            note_n  = REST_NOTE;
                            nv_n    = 1'b0;
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = FETCH;
                        end
                    end else if (bus.pause_tgl) begin
                        state_n = PAUSE;
                    end
                end
                PAUSE: if (bus.pause_tgl) state_n = PLAY;
                DONE: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    song_n  = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.mem_addr   = {song_lat, idx};
    assign bus.note_out   = note_r;
    assign bus.note_valid = nv_r && (state != PAUSE);
    assign bus.song_end   = (state == DONE);
    assign bus.playing    = (state inside {FETCH, LOAD, PLAY});

endmodule

// File: tb/tb_music_player_ctrl.sv
// Scoreboard bench for music_player_ctrl: directed cycles push expected
// outputs, a monitor pops and compares one entry after every clock edge.
module tb_music_player_ctrl;
    localparam int IDX_W = 6;
    localparam int DUR_W = 12;
    localparam int AW    = IDX_W + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    music_player_ctrl_if #(.IDX_W(IDX_W)) bus();

    music_player_ctrl #(.IDX_W(IDX_W), .DUR_W(DUR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] rom [0:255];
    always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    note;
        logic          nv;
        logic          en;
        logic          pl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    armed    = 1'b0;
    logic       rst_drv = 1'b0;
    logic [1:0] sel_drv = 2'd0;

    initial begin : monitor
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (armed) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: DUT output with no expected entry");
                end
            end else begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {bus.mem_addr, bus.note_out, bus.note_valid, bus.song_end, bus.playing};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got addr=%h note=%h valid=%b end=%b play=%b, expected addr=%h note=%h valid=%b end=%b play=%b",
                             nm, got.addr, got.note, got.nv, got.en, got.pl,
                             e.addr, e.note, e.nv, e.en, e.pl);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input logic st, input logic pt, input logic tk,
                       input logic [AW-1:0] a, input logic [3:0] n,
                       input logic nv, input logic en, input logic pl,
                       input string nm);
        @(negedge clk);
        reset         = rst_drv;
        bus.song_sel  = sel_drv;
        bus.start     = st;
        bus.pause_tgl = pt;
        bus.tick      = tk;
        exp_q.push_back(exp_t'({a, n, nv, en, pl}));
        name_q.push_back(nm);
        armed = 1'b1;
    endtask

    initial begin : stimulus
        logic [AW-1:0] a;
        reset         = 1'b0;
        bus.song_sel  = 2'd0;
        bus.start     = 1'b0;
        bus.pause_tgl = 1'b0;
        bus.tick      = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        rom[8'h00] = 16'h9005;
        rom[8'h40] = 16'h7000;
        rom[8'h41] = 16'h0005;
        rom[8'h42] = 16'h5003;
        rom[8'h80] = 16'h3002;
        for (int i = 8'hC0; i < 256; i++) rom[i] = 16'h1001;

        // reset overrides start
        rst_drv = 1'b0;
        cyc(1,0,0, 8'h00,4'h0,0,0,0, "reset_with_start");
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "reset_hold");
        rst_drv = 1'b1;
        cyc(0,1,0, 8'h00,4'h0,0,0,0, "idle_pause_ignored");
        cyc(0,0,1, 8'h00,4'h0,0,0,0, "idle_tick_ignored");

        // song 2: note 3 for 2 ticks, then end marker
        sel_drv = 2'd2;
        cyc(1,0,0, 8'h80,4'h0,0,0,1, "s2_fetch_n1");
        cyc(0,0,0, 8'h80,4'h0,0,0,1, "s2_load");
        cyc(0,0,0, 8'h80,4'h3,1,0,1, "s2_note_n3");
        cyc(0,0,1, 8'h80,4'h3,1,0,1, "s2_tick1");
        cyc(0,0,1, 8'h81,4'h3,1,0,1, "s2_tick2_fetch");
        cyc(0,0,0, 8'h81,4'h3,1,0,1, "s2_load_end");
        cyc(0,0,0, 8'h81,4'h0,0,1,0, "s2_done");
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "s2_idle");
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "s2_single_end");

        // song 1: skipped zero-length note 7, rest for 5 ticks, note 5 with pause on final tick
        sel_drv = 2'd1;
        cyc(1,0,0, 8'h40,4'h0,0,0,1, "s1_fetch0");
        cyc(0,0,0, 8'h40,4'h0,0,0,1, "s1_load0");
        cyc(0,0,0, 8'h41,4'h0,0,0,1, "s1_skip_fetch1");
        cyc(0,0,0, 8'h41,4'h0,0,0,1, "s1_load1");
        cyc(0,0,0, 8'h41,4'h0,0,0,1, "s1_rest_play");
        for (int i = 0; i < 4; i++) cyc(0,0,1, 8'h41,4'h0,0,0,1, "s1_rest_tick");
        cyc(0,0,1, 8'h42,4'h0,0,0,1, "s1_rest_last_tick");
        cyc(0,0,0, 8'h42,4'h0,0,0,1, "s1_load2");
        cyc(0,0,0, 8'h42,4'h5,1,0,1, "s1_note5");
        cyc(0,0,1, 8'h42,4'h5,1,0,1, "s1_n5_tick1");
        cyc(0,0,1, 8'h42,4'h5,1,0,1, "s1_n5_tick2");
        cyc(0,1,1, 8'h43,4'h5,1,0,1, "s1_final_tick_beats_pause");
        cyc(0,0,0, 8'h43,4'h5,1,0,1, "s1_load3");
        cyc(0,0,0, 8'h43,4'h0,0,1,0, "s1_done");
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "s1_idle");

        // song 0: note 9 for 5 ticks with 10 ticks spent paused
        sel_drv = 2'd0;
        cyc(1,0,0, 8'h00,4'h0,0,0,1, "s0_fetch");
        cyc(0,0,0, 8'h00,4'h0,0,0,1, "s0_load");
        cyc(0,0,0, 8'h00,4'h9,1,0,1, "s0_note9");
        cyc(0,0,1, 8'h00,4'h9,1,0,1, "s0_tick1");
        cyc(0,1,0, 8'h00,4'h9,0,0,0, "s0_pause");
        for (int i = 0; i < 10; i++) cyc(0,0,1, 8'h00,4'h9,0,0,0, "s0_paused_tick");
        cyc(0,1,0, 8'h00,4'h9,1,0,1, "s0_resume");
        for (int i = 0; i < 3; i++) cyc(0,0,1, 8'h00,4'h9,1,0,1, "s0_tick_remaining");
        cyc(0,0,1, 8'h01,4'h9,1,0,1, "s0_last_tick");
        cyc(0,0,0, 8'h01,4'h9,1,0,1, "s0_load_end");
        cyc(0,0,0, 8'h01,4'h0,0,1,0, "s0_done");
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "s0_idle");

        // song 3: 64 one-tick notes, ends after index 63 without wrapping
        sel_drv = 2'd3;
        cyc(1,0,0, 8'hC0,4'h0,0,0,1, "s3_fetch0");
        for (int i = 0; i < 64; i++) begin
            a = AW'(8'hC0 + i);
            cyc(0,0,0, a, (i == 0) ? 4'h0 : 4'h1, (i != 0), 0, 1, "s3_load");
            cyc(0,0,0, a, 4'h1, 1, 0, 1, "s3_play");
            if (i < 63) cyc(0,0,1, a + AW'(1), 4'h1, 1, 0, 1, "s3_next");
            else        cyc(0,0,1, 8'hFF, 4'h0, 0, 1, 0, "s3_done_at_63");
        end
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "s3_idle_no_wrap");

        // reset with start mid-note aborts silently
        sel_drv = 2'd2;
        cyc(1,0,0, 8'h80,4'h0,0,0,1, "rst_fetch");
        cyc(0,0,0, 8'h80,4'h0,0,0,1, "rst_load");
        cyc(0,0,0, 8'h80,4'h3,1,0,1, "rst_play");
        rst_drv = 1'b0;
        cyc(1,0,1, 8'h00,4'h0,0,0,0, "rst_mid_note");
        rst_drv = 1'b1;
        cyc(0,0,0, 8'h00,4'h0,0,0,0, "rst_no_song_end");

        // start during PLAY (with pause and tick) restarts on the new song
        cyc(1,0,0, 8'h80,4'h0,0,0,1, "rs_fetch");
        cyc(0,0,0, 8'h80,4'h0,0,0,1, "rs_load");
        cyc(0,0,0, 8'h80,4'h3,1,0,1, "rs_play");
        sel_drv = 2'd1;
        cyc(1,1,1, 8'h40,4'h3,1,0,1, "rs_restart_new_song");
        cyc(0,0,0, 8'h40,4'h3,1,0,1, "rs_load0");
        cyc(0,0,0, 8'h41,4'h3,1,0,1, "rs_skip");
        cyc(0,0,0, 8'h41,4'h3,1,0,1, "rs_load1");
        cyc(0,0,0, 8'h41,4'h0,0,0,1, "rs_rest_play");

        @(posedge clk);
        #2;
        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
